alu_cmd_sequencer: RTL and testbench

- Command front-end for the 4-bit ALU core (alu_4bit).
- Accepts operand/opcode commands through a valid/ready handshake and buffers them in a small FIFO.
- Issues one command at a time to the combinational ALU core through registered operand outputs.
- Captures result and flags into a held output register with its own valid/ready handshake.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_cmd_fifo.sv | 65 ++++++
 rtl/alu_cmd_sequencer.sv | 175 +++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the alu_cmd_sequencer front-end and its FIFO.
//   DATA_W      : operand/result width of the alu_4bit core
//   SEL_W       : opcode width
//   alu_op_e    : opcode encoding understood by the core
//   alu_cmd_t   : one queued command {a, b, sel, chain}
//   seq_state_e : issue FSM states
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int SEL_W  = 3;

    typedef enum logic [SEL_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOT = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [SEL_W-1:0]  sel;
        logic              chain;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        STALL = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous FIFO of alu_cmd_t commands, asynchronous active-high reset.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// Ports:
//   clk, rst  : clock (rising edge), async active-high reset
//   i_push    : write request (ignored while full)
//   i_data    : command to write
//   i_pop     : read request (ignored while empty)
//   o_data    : head of the queue (valid while !o_empty)
//   o_full    : DEPTH entries held
//   o_empty   : no entries held
// -----------------------------------------------------------------------------
module alu_cmd_fifo #(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  alu_pkg::alu_cmd_t i_data,
    input  logic             i_pop,
    output alu_pkg::alu_cmd_t o_data,
    output logic             o_full,
    output logic             o_empty
);
    import alu_pkg::*;

    localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(DEPTH);

    alu_cmd_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop  && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
// Command front-end for the combinational alu_4bit core. Commands are queued
// in alu_cmd_fifo, issued one at a time through registered operand outputs,
// and the core's result/flags are captured into a held result register.
// Optional feature macro: ACC_CHAIN_EN (chain = 1 takes A from the last result).
// Ports:
//   clk, rst                     : clock, async active-high reset
//   cmd_valid/cmd_ready          : command handshake (cmd_ready = FIFO not full)
//   cmd_a, cmd_b, cmd_sel        : command operands and opcode
//   cmd_chain                    : use last result as A (ACC_CHAIN_EN only)
//   alu_a, alu_b, alu_sel        : registered operands/opcode to the core
//   alu_y, alu_carry, alu_zero   : core result and flags
//   res_valid/res_ready          : result handshake
//   res_y, res_carry, res_zero   : captured result and flags
//   busy                         : FIFO non-empty or FSM not IDLE
// DATA_W/SEL_W must match alu_pkg; FIFO_DEPTH must be a power of two >= 2.
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int DATA_W     = alu_pkg::DATA_W,
    parameter int SEL_W      = alu_pkg::SEL_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic              cmd_chain,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_y,
    output logic              res_carry,
    output logic              res_zero,
    output logic              busy
);
    import alu_pkg::*;

    seq_state_e        r_state;
    seq_state_e        w_next_state;
    alu_cmd_t          w_cmd_in;
    alu_cmd_t          w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_capture;
    logic              w_slot_free;
    logic [DATA_W-1:0] w_issue_a;

    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [SEL_W-1:0]  r_alu_sel;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_y;
    logic              r_res_carry;
    logic              r_res_zero;

    assign w_cmd_in    = '{a: cmd_a, b: cmd_b, sel: cmd_sel, chain: cmd_chain};
    assign w_push      = cmd_valid && !w_full;
    assign w_slot_free = !r_res_valid || res_ready;

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_cmd_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef ACC_CHAIN_EN
    logic [DATA_W-1:0] r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_acc <= '0;
        else if (w_capture) r_acc <= alu_y;
    end

    // A capture in the same cycle as the pop means r_acc is one result stale,
    // so forward the core output directly.
    always_comb begin
        w_issue_a = w_head.a;
        if (w_head.chain) w_issue_a = w_capture ? alu_y : r_acc;
    end
`else
    logic w_unused_chain;
    assign w_unused_chain = w_head.chain;
    assign w_issue_a      = w_head.a;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // EXEC and STALL share one rule: in STALL res_valid is always 1, so
    // w_slot_free reduces to res_ready there.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = EXEC;
                end
            end
            EXEC, STALL: begin
                if (w_slot_free) begin
                    w_capture = 1'b1;
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = EXEC;
                    end else begin
                        w_next_state = IDLE;
                    end
                end else begin
                    w_next_state = STALL;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= '0;
            r_res_valid <= 1'b0;
            r_res_y     <= '0;
            r_res_carry <= 1'b0;
            r_res_zero  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_alu_a   <= w_issue_a;
                r_alu_b   <= w_head.b;
                r_alu_sel <= w_head.sel;
            end
            if (w_capture) begin
                r_res_valid <= 1'b1;
                r_res_y     <= alu_y;
                r_res_carry <= alu_carry;
                r_res_zero  <= alu_zero;
            end else if (res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign cmd_ready = !w_full;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign res_valid = r_res_valid;
    assign res_y     = r_res_y;
    assign res_carry = r_res_carry;
    assign res_zero  = r_res_zero;
    assign busy      = !w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    typedef struct {
        logic [3:0] y;
        logic       c;
        logic       z;
    } exp_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
        logic       chain;
        logic [3:0] y;
        logic       c;
        logic       z;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_sel;
    logic       cmd_chain;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_y;
    logic       alu_carry;
    logic       alu_zero;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_y;
    logic       res_carry;
    logic       res_zero;
    logic       busy;

    int   n_tests   = 0;
    int   n_fail    = 0;
    int   n_results = 0;
    int   base_res;
    logic stress    = 1'b0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [4:0] t;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .DATA_W     (4),
        .SEL_W      (3),
        .FIFO_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_sel   (cmd_sel),
        .cmd_chain (cmd_chain),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_y     (alu_y),
        .alu_carry (alu_carry),
        .alu_zero  (alu_zero),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_carry (res_carry),
        .res_zero  (res_zero),
        .busy      (busy)
    );

    // Behavioural stand-in for the combinational alu_4bit core.
    always_comb begin
        t         = '0;
        alu_y     = '0;
        alu_carry = 1'b0;
        case (alu_sel)
            ALU_ADD: begin t = {1'b0, alu_a} + {1'b0, alu_b}; alu_y = t[3:0]; alu_carry = t[4]; end
            ALU_SUB: begin t = {1'b0, alu_a} - {1'b0, alu_b}; alu_y = t[3:0]; alu_carry = t[4]; end
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_XOR: alu_y = alu_a ^ alu_b;
            ALU_NOT: alu_y = ~alu_a;
            ALU_SHL: begin alu_y = {alu_a[2:0], 1'b0}; alu_carry = alu_a[3]; end
            default: begin alu_y = {1'b0, alu_a[3:1]}; alu_carry = alu_a[0]; end
        endcase
    end
    assign alu_zero = (alu_y == 4'd0);

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic vec_t mk(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                                input logic chain, input logic [3:0] y, input logic c, input logic z);
        vec_t v;
        v.a = a; v.b = b; v.sel = sel; v.chain = chain; v.y = y; v.c = c; v.z = z;
        return v;
    endfunction

    // Holds the command until accepted; expected result is queued on acceptance.
    task automatic push_cmd(input vec_t v);
        bit ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_a     = v.a;
        cmd_b     = v.b;
        cmd_sel   = v.sel;
        cmd_chain = v.chain;
        for (int i = 0; i < 64; i++) begin
            ok = cmd_ready;
            if (ok) sb_q.push_back('{y: v.y, c: v.c, z: v.z});
            @(posedge clk);
            #1;
            if (ok) break;
        end
        cmd_valid = 1'b0;
        cmd_chain = 1'b0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    // Monitor: every result transfer is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            n_results++;
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("result_y_c_z", {res_y, res_carry, res_zero}, {mon_e.y, mon_e.c, mon_e.z});
            end
        end
    end

    always @(posedge clk) begin
        if (stress) begin
            #1;
            res_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    vec_t stall_v [4];
    vec_t stress_v [10];

    initial begin
        stall_v[0] = mk(4'd9,  4'd4,  ALU_SUB, 1'b0, 4'd5, 1'b0, 1'b0);
        stall_v[1] = mk(4'd12, 4'd10, ALU_AND, 1'b0, 4'd8, 1'b0, 1'b0);
        stall_v[2] = mk(4'd5,  4'd2,  ALU_OR,  1'b0, 4'd7, 1'b0, 1'b0);
        stall_v[3] = mk(4'd6,  4'd6,  ALU_XOR, 1'b0, 4'd0, 1'b0, 1'b1);

        stress_v[0] = mk(4'd15, 4'd1,  ALU_ADD, 1'b0, 4'd0,  1'b1, 1'b1);
        stress_v[1] = mk(4'd3,  4'd5,  ALU_SUB, 1'b0, 4'd14, 1'b1, 1'b0);
        stress_v[2] = mk(4'd7,  4'd7,  ALU_SUB, 1'b0, 4'd0,  1'b0, 1'b1);
        stress_v[3] = mk(4'd15, 4'd0,  ALU_AND, 1'b0, 4'd0,  1'b0, 1'b1);
        stress_v[4] = mk(4'd8,  4'd1,  ALU_OR,  1'b0, 4'd9,  1'b0, 1'b0);
        stress_v[5] = mk(4'd10, 4'd5,  ALU_XOR, 1'b0, 4'd15, 1'b0, 1'b0);
        stress_v[6] = mk(4'd10, 4'd0,  ALU_NOT, 1'b0, 4'd5,  1'b0, 1'b0);
        stress_v[7] = mk(4'd9,  4'd0,  ALU_SHL, 1'b0, 4'd2,  1'b1, 1'b0);
        stress_v[8] = mk(4'd3,  4'd0,  ALU_SHR, 1'b0, 4'd1,  1'b1, 1'b0);
        stress_v[9] = mk(4'd8,  4'd0,  ALU_SHL, 1'b0, 4'd0,  1'b1, 1'b1);

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_sel   = '0;
        cmd_chain = 1'b0;
        res_ready = 1'b1;
        tick(2);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_alu_a",     alu_a,     0);
        chk("reset_alu_sel",   alu_sel,   0);
        chk("reset_busy",      busy,      0);
        chk("reset_cmd_ready", cmd_ready, 1);
        rst = 1'b0;
        tick(1);

        // Single ADD: latency and busy.
        push_cmd(mk(4'd3, 4'd5, ALU_ADD, 1'b0, 4'd8, 1'b0, 1'b0));
        chk("lat0_res_valid", res_valid, 0);
        chk("lat0_busy",      busy,      1);
        tick(1);
        chk("lat1_alu_a",     alu_a,     3);
        chk("lat1_alu_b",     alu_b,     5);
        chk("lat1_alu_sel",   alu_sel,   ALU_ADD);
        chk("lat1_res_valid", res_valid, 0);
        tick(1);
        chk("lat2_res_valid", res_valid, 1);
        chk("lat2_res_y",     res_y,     8);
        chk("lat2_busy",      busy,      0);
        tick(1);
        chk("lat3_res_valid", res_valid, 0);

        // Back-pressure: four commands with res_ready low.
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd(stall_v[i]);
        chk("stall_cmd_ready", cmd_ready, 0);
        chk("stall_res_valid", res_valid, 1);
        chk("stall_res_y",     res_y,     5);
        chk("stall_alu_a",     alu_a,     12);
        chk("stall_busy",      busy,      1);
        tick(3);
        chk("stall_hold_res_y",     res_y,     5);
        chk("stall_hold_cmd_ready", cmd_ready, 0);
        res_ready = 1'b1;
        tick(3);
        chk("drain_no_gap",       res_valid,   1);
        tick(1);
        chk("drain_done_valid",   res_valid,   0);
        chk("drain_done_sb",      sb_q.size(), 0);

        // Wrap-around ADD and capture+drain in the same cycle.
        push_cmd(mk(4'd9, 4'd7, ALU_ADD, 1'b0, 4'd0, 1'b1, 1'b1));
        push_cmd(mk(4'd1, 4'd1, ALU_ADD, 1'b0, 4'd2, 1'b0, 1'b0));
        tick(1);
        chk("wrap_res_valid", res_valid, 1);
        chk("wrap_res_y",     res_y,     0);
        chk("wrap_carry",     res_carry, 1);
        chk("wrap_zero",      res_zero,  1);
        tick(1);
        chk("b2b_res_valid",  res_valid, 1);
        chk("b2b_res_y",      res_y,     2);
        tick(2);

        // Chained command, back-to-back (forwarded) then after idle (accumulator).
        push_cmd(mk(4'd2, 4'd3, ALU_ADD, 1'b0, 4'd5, 1'b0, 1'b0));
`ifdef ACC_CHAIN_EN
        push_cmd(mk(4'd1, 4'd4, ALU_ADD, 1'b1, 4'd9, 1'b0, 1'b0));
`else
        push_cmd(mk(4'd1, 4'd4, ALU_ADD, 1'b1, 4'd5, 1'b0, 1'b0));
`endif
        tick(4);
        push_cmd(mk(4'd2, 4'd3, ALU_ADD, 1'b0, 4'd5, 1'b0, 1'b0));
        tick(5);
`ifdef ACC_CHAIN_EN
        push_cmd(mk(4'd1, 4'd4, ALU_ADD, 1'b1, 4'd9, 1'b0, 1'b0));
`else
        push_cmd(mk(4'd1, 4'd4, ALU_ADD, 1'b1, 4'd5, 1'b0, 1'b0));
`endif
        tick(4);
        chk("chain_sb_empty", sb_q.size(), 0);

        // Reset with a held result, one command in flight and a full FIFO.
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd(stall_v[i]);
        chk("prerst_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_res_y",     res_y,     0);
        chk("midrst_flags",     {res_carry, res_zero}, 0);
        chk("midrst_alu_a",     alu_a,     0);
        chk("midrst_alu_b",     alu_b,     0);
        chk("midrst_alu_sel",   alu_sel,   0);
        chk("midrst_busy",      busy,      0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        res_ready = 1'b1;
        base_res  = n_results;
        tick(6);
        chk("postrst_no_result", n_results - base_res, 0);
        chk("postrst_busy",      busy, 0);

        // Stress: random gaps between pushes and random res_ready.
        stress = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) begin
                push_cmd(stress_v[i]);
                tick($urandom_range(0, 2));
            end
        end
        stress = 1'b0;
        tick(1);
        res_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (sb_q.size() == 0) break;
            tick(1);
        end
        chk("stress_drained", sb_q.size(), 0);
        tick(2);
        chk("stress_final_valid", res_valid, 0);
        chk("stress_final_busy",  busy,      0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
